// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: the NOP word presented while empty and the
// occupancy state encoding used by the fetch/decode skid stage.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/if_id_stage_if.sv
// Valid/ready bundle for one side of the fetch/decode boundary.
// The producer drives valid/instr/pc/pcplus4, the consumer drives ready.
interface if_id_stage_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
);
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pcplus4;
    logic               ready;

    modport master (output valid, instr, pc, pcplus4, input ready);
    modport slave  (input valid, instr, pc, pcplus4, output ready);
endinterface

// File: rtl/if_id_stage_flopenrc.sv
// Enable flop with synchronous clear and asynchronous reset; both reset and
// clear load CLR_VAL so an empty entry always holds the same idle word.
module flopenrc #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= CLR_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Two-entry skid buffer between fetch and decode; ready is decoded from the
// occupancy register only, so no combinational path runs from i_ready back.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | no entry held, outputs idle (NOP / pc 0)
//   ST_ONE   | main register holds the presented entry
//   ST_TWO   | main presented, skid holds the next entry
//   2'd3     | illegal, recovers to ST_EMPTY
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_ready,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc,
    output logic [PC_W-1:0]    o_pcplus4,
    input  logic               i_ready
);

    localparam int                 ENT_W   = INSTR_W + PC_W;
    localparam logic [ENT_W-1:0]   ENT_NOP = {INSTR_W'(NOP_INSTR), {PC_W{1'b0}}};

    stage_state_t     state;
    logic             accept;
    logic             take;
    logic             main_en;
    logic             main_clr;
    logic             skid_en;
    logic             skid_clr;
    logic [ENT_W-1:0] in_ent;
    logic [ENT_W-1:0] main_d;
    logic [ENT_W-1:0] main_q;
    logic [ENT_W-1:0] skid_q;

    assign o_ready = (state != ST_TWO);
    assign o_valid = (state != ST_EMPTY);
    assign accept  = i_valid & o_ready & ~i_flush;
    assign take    = o_valid & i_ready;
    assign in_ent  = {i_instr, i_pc};

    // Main is cleared whenever it drains so outputs read NOP/0 while idle.
    always_comb begin
        main_en  = 1'b0;
        main_clr = 1'b0;
        skid_en  = 1'b0;
        skid_clr = 1'b0;
        main_d   = in_ent;
        if (i_flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_en = accept;
                ST_ONE: begin
                    if (accept && take) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        skid_en = 1'b1;
                    end else if (take) begin
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        main_d   = skid_q;
                        main_en  = 1'b1;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else if (i_flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_ONE;
                ST_ONE: begin
                    if (accept && !take) begin
                        state <= ST_TWO;
                    end else if (take && !accept) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_TWO:   if (take) state <= ST_ONE;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    flopenrc #(.WIDTH(ENT_W), .CLR_VAL(ENT_NOP)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .clr   (main_clr),
        .d     (main_d),
        .q     (main_q)
    );

    flopenrc #(.WIDTH(ENT_W), .CLR_VAL(ENT_NOP)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .clr   (skid_clr),
        .d     (in_ent),
        .q     (skid_q)
    );

    assign o_instr   = main_q[ENT_W-1:PC_W];
    assign o_pc      = main_q[PC_W-1:0];
    assign o_pcplus4 = o_pc + PC_W'(4);

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for the fetch/decode skid stage: reset, single transfer,
// back-pressure ordering, streaming, flush and mid-transfer reset.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic reset;
    logic flush;
    int   n_cmp;
    int   n_err;

    if_id_stage_if #(.INSTR_W(32), .PC_W(32)) fetch_bus ();
    if_id_stage_if #(.INSTR_W(32), .PC_W(32)) dec_bus ();

    if_id_stage #(.INSTR_W(32), .PC_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (fetch_bus.valid),
        .i_instr   (fetch_bus.instr),
        .i_pc      (fetch_bus.pc),
        .o_ready   (fetch_bus.ready),
        .i_flush   (flush),
        .o_valid   (dec_bus.valid),
        .o_instr   (dec_bus.instr),
        .o_pc      (dec_bus.pc),
        .o_pcplus4 (dec_bus.pcplus4),
        .i_ready   (dec_bus.ready)
    );

    assign fetch_bus.pcplus4 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        fetch_bus.valid = v;
        fetch_bus.instr = ins;
        fetch_bus.pc    = pc;
    endtask

    task automatic expect_entry(input string tag, input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, "_valid"}, 64'(dec_bus.valid), 64'd1);
        chk({tag, "_instr"}, 64'(dec_bus.instr), 64'(ins));
        chk({tag, "_pc"},    64'(dec_bus.pc),    64'(pc));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 64'(dec_bus.valid),   64'd0);
        chk({tag, "_ready"}, 64'(fetch_bus.ready), 64'd1);
        chk({tag, "_instr"}, 64'(dec_bus.instr),   64'(NOP));
        chk({tag, "_pc"},    64'(dec_bus.pc),      64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        flush = 1'b0;
        dec_bus.ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        expect_idle("rst");
        reset = 1'b0;

        // single transfer, one-cycle latency
        dec_bus.ready = 1'b1;
        offer(1'b1, 32'hE3A0_0001, 32'h100);
        tick();
        expect_entry("single", 32'hE3A0_0001, 32'h100);
        chk("single_pc4", 64'(dec_bus.pcplus4), 64'h104);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        expect_idle("single_drain");

        // back-pressure: A,B held, C waits at fetch
        dec_bus.ready = 1'b0;
        offer(1'b1, 32'hAAAA_0001, 32'h200);
        tick();
        expect_entry("bp_a", 32'hAAAA_0001, 32'h200);
        chk("bp_a_ready", 64'(fetch_bus.ready), 64'd1);
        offer(1'b1, 32'hBBBB_0002, 32'h204);
        tick();
        chk("bp_two_ready", 64'(fetch_bus.ready), 64'd0);
        expect_entry("bp_hold_a", 32'hAAAA_0001, 32'h200);
        offer(1'b1, 32'hCCCC_0003, 32'h208);
        tick();
        expect_entry("bp_stable_a", 32'hAAAA_0001, 32'h200);
        chk("bp_stable_ready", 64'(fetch_bus.ready), 64'd0);
        dec_bus.ready = 1'b1;
        tick();
        expect_entry("bp_b", 32'hBBBB_0002, 32'h204);
        chk("bp_b_ready", 64'(fetch_bus.ready), 64'd1);
        tick();
        expect_entry("bp_c", 32'hCCCC_0003, 32'h208);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        expect_idle("bp_drain");

        // streaming, one per cycle
        for (int k = 0; k < 8; k++) begin
            offer(1'b1, 32'h0000_1000 + 32'(k), 32'h300 + 32'(4 * k));
            tick();
            expect_entry("stream", 32'h0000_1000 + 32'(k), 32'h300 + 32'(4 * k));
            chk("stream_ready", 64'(fetch_bus.ready), 64'd1);
            chk("stream_pc4", 64'(dec_bus.pcplus4), 64'h304 + 64'(4 * k));
        end
        offer(1'b0, 32'h0, 32'h0);
        tick();
        expect_idle("stream_drain");

        // flush from TWO with a simultaneous offer
        dec_bus.ready = 1'b0;
        offer(1'b1, 32'hDDDD_0004, 32'h400);
        tick();
        offer(1'b1, 32'hEEEE_0005, 32'h404);
        tick();
        chk("fl_two_ready", 64'(fetch_bus.ready), 64'd0);
        flush = 1'b1;
        offer(1'b1, 32'hFFFF_0006, 32'h408);
        tick();
        expect_idle("flush");
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        dec_bus.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_idle("flush_after");
        end

        // flush beats an offer while empty
        flush = 1'b1;
        offer(1'b1, 32'h1234_5678, 32'h500);
        tick();
        expect_idle("flush_empty");
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);

        // reset in TWO, then pc wrap
        dec_bus.ready = 1'b0;
        offer(1'b1, 32'h7777_0007, 32'h600);
        tick();
        offer(1'b1, 32'h8888_0008, 32'h604);
        tick();
        chk("rst2_two_ready", 64'(fetch_bus.ready), 64'd0);
        offer(1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        #1;
        expect_idle("rst_mid");
        #1;
        reset = 1'b0;
        offer(1'b1, 32'h9999_0009, 32'hFFFF_FFFC);
        tick();
        expect_entry("wrap", 32'h9999_0009, 32'hFFFF_FFFC);
        chk("wrap_pc4", 64'(dec_bus.pcplus4), 64'd0);
        offer(1'b0, 32'h0, 32'h0);
        dec_bus.ready = 1'b1;
        tick();
        expect_idle("wrap_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
